// File: rtl/mem_stage_pkg.sv
// Shared constants and helpers for the memory-access stage.
package mem_stage_pkg;

  localparam int DWIDTH = 32;
  localparam int BE_W   = DWIDTH / 8;

  localparam logic [DWIDTH-1:0] ZERO_DW = {DWIDTH{1'b0}};

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    HOLD = 2'd3
  } mem_state_e;

  // Byte offset forced to the natural alignment of the access size
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   align_off = a;
      2'b01:   align_off = {a[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] store_lanes(input logic [2:0] f3, input logic [DWIDTH-1:0] d);
    case (f3[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if
  import mem_stage_pkg::*;
();
  logic              dmem_req;
  logic              dmem_we;
  logic [DWIDTH-1:0] dmem_addr;
  logic [DWIDTH-1:0] dmem_wdata;
  logic [BE_W-1:0]   dmem_be;
  logic              dmem_ready;
  logic              dmem_rsp_valid;
  logic [DWIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shifts the addressed bytes down and sign/zero-extends them.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DWIDTH-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] data
);
  logic [DWIDTH-1:0] shifted_s;

  // Byte-lane shift followed by size/sign extension
  always_comb begin
    shifted_s = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_BU:   data = {24'h000000, shifted_s[7:0]};
      F3_HU:   data = {16'h0000, shifted_s[15:0]};
      default: data = shifted_s;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests, aligns loads, stalls upstream while busy.
// Build option MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of masking low address bits.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] pc_in,
  input  logic [DWIDTH-1:0] alu_result_in,
  input  logic [DWIDTH-1:0] store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              regW_in,
  input  logic [1:0]        WBSel_in,
  input  logic              memR_in,
  input  logic              memW_in,
  input  logic [2:0]        funct3_in,
  mem_stage_if.master       dmem,
  output logic              out_valid,
  output logic [DWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] alu_result_out,
  output logic [DWIDTH-1:0] mem_data_out,
  output logic [4:0]        rd_out,
  output logic              regW_out,
  output logic [1:0]        WBSel_out,
  output logic              stall_req,
  output logic              misalign
);
  mem_state_e        state_r, state_s;
  logic [DWIDTH-1:0] pc_r, alu_r, wdata_r, mem_data_r, load_data_s;
  logic [BE_W-1:0]   be_r;
  logic [4:0]        rd_r;
  logic [2:0]        f3_r;
  logic [1:0]        off_r, off_s, wbsel_r;
  logic              regw_r, we_r, misalign_r;
  logic              is_mem_s, accept_s, mis_s;

  assign is_mem_s = memR_in | memW_in;
  assign accept_s = (state_r == IDLE) & in_valid & ~flush & is_mem_s & ~stall_in;
  assign off_s    = align_off(funct3_in, alu_result_in[1:0]);
`ifdef MISALIGN_TRAP_EN
  assign mis_s    = is_misaligned(funct3_in, alu_result_in[1:0]);
`else
  assign mis_s    = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .off    (off_r),
    .funct3 (f3_r),
    .data   (load_data_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Op capture on acceptance; load result capture on response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= ZERO_DW;
      alu_r      <= ZERO_DW;
      wdata_r    <= ZERO_DW;
      mem_data_r <= ZERO_DW;
      be_r       <= 4'b0000;
      rd_r       <= 5'd0;
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
      wbsel_r    <= 2'b00;
      regw_r     <= 1'b0;
      we_r       <= 1'b0;
      misalign_r <= 1'b0;
    end else if (accept_s) begin
      pc_r       <= pc_in;
      alu_r      <= alu_result_in;
      wdata_r    <= store_lanes(funct3_in, store_data_in);
      mem_data_r <= ZERO_DW;
      be_r       <= byte_en(funct3_in, off_s);
      rd_r       <= rd_in;
      f3_r       <= funct3_in;
      off_r      <= off_s;
      wbsel_r    <= WBSel_in;
      regw_r     <= regW_in & ~memW_in & ~mis_s;
      we_r       <= memW_in;
      misalign_r <= mis_s;
    end else if ((state_r == RSP) && dmem.dmem_rsp_valid) begin
      mem_data_r <= load_data_s;
    end else begin
      mem_data_r <= mem_data_r;
    end
  end

  // Next state; an accepted access always runs to HOLD regardless of flush
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = mis_s ? HOLD : REQ;
        else          state_s = IDLE;
      end
      REQ: begin
        if (dmem.dmem_ready) state_s = we_r ? HOLD : RSP;
        else                 state_s = REQ;
      end
      RSP: begin
        if (dmem.dmem_rsp_valid) state_s = HOLD;
        else                     state_s = RSP;
      end
      HOLD: begin
        if (!stall_in) state_s = IDLE;
        else           state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs: combinational pass-through in IDLE, captured registers otherwise
  always_comb begin
    dmem.dmem_req   = (state_r == REQ);
    dmem.dmem_we    = we_r;
    dmem.dmem_addr  = {alu_r[DWIDTH-1:2], 2'b00};
    dmem.dmem_wdata = wdata_r;
    dmem.dmem_be    = be_r;
    out_valid       = 1'b0;
    pc_out          = pc_r;
    alu_result_out  = alu_r;
    mem_data_out    = mem_data_r;
    rd_out          = rd_r;
    regW_out        = 1'b0;
    WBSel_out       = wbsel_r;
    stall_req       = 1'b0;
    misalign        = 1'b0;
    case (state_r)
      IDLE: begin
        pc_out         = pc_in;
        alu_result_out = alu_result_in;
        mem_data_out   = ZERO_DW;
        rd_out         = rd_in;
        WBSel_out      = WBSel_in;
        if (rst && in_valid && !flush && !is_mem_s) begin
          out_valid = 1'b1;
          regW_out  = regW_in;
        end else begin
          out_valid = 1'b0;
          regW_out  = 1'b0;
        end
      end
      REQ, RSP: stall_req = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        regW_out  = regw_r;
        misalign  = misalign_r;
        stall_req = stall_in;
      end
      default: stall_req = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected mw_reg transfers.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  wbsel;
    logic        mis;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, stall_in, in_valid;
  logic [31:0] pc_in, alu_result_in, store_data_in;
  logic [4:0]  rd_in;
  logic        regW_in, memR_in, memW_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic        out_valid, regW_out, stall_req, misalign;
  logic [31:0] pc_out, alu_result_out, mem_data_out;
  logic [4:0]  rd_out;
  logic [1:0]  WBSel_out;

  mem_stage_if dmem_bus();

  mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .in_valid(in_valid),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .rd_in(rd_in), .regW_in(regW_in), .WBSel_in(WBSel_in), .memR_in(memR_in),
    .memW_in(memW_in), .funct3_in(funct3_in), .dmem(dmem_bus),
    .out_valid(out_valid), .pc_out(pc_out), .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out), .rd_out(rd_out), .regW_out(regW_out),
    .WBSel_out(WBSel_out), .stall_req(stall_req), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  exp_t        sb[$];
  int          stall_cnt, hs_cnt, req_cnt, ready_wait;
  bit          rsp_pending, suppress_rsp;
  logic [31:0] rsp_data, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_we;
  logic        last_ov, last_regw, last_sr, last_mis;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    last_ov = out_valid; last_regw = regW_out; last_sr = stall_req;
    last_mis = misalign; last_data = mem_data_out;
    if (stall_req) stall_cnt++;
    if (dmem_bus.dmem_req) begin
      req_cnt++;
      chk("dmem_addr", dmem_bus.dmem_addr, exp_addr);
      chk("dmem_be", {28'h0, dmem_bus.dmem_be}, {28'h0, exp_be});
      chk("dmem_we", {31'h0, dmem_bus.dmem_we}, {31'h0, exp_we});
      if (exp_we) chk("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
      if (dmem_bus.dmem_ready) begin
        hs_cnt++;
        if (!dmem_bus.dmem_we) rsp_pending = 1'b1;
      end
    end
    if (out_valid && !stall_in) begin
      chk("out_expected", {31'h0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("alu_result_out", alu_result_out, e.alu);
        chk("rd_out", {27'h0, rd_out}, {27'h0, e.rd});
        chk("regW_out", {31'h0, regW_out}, {31'h0, e.regw});
        chk("WBSel_out", {30'h0, WBSel_out}, {30'h0, e.wbsel});
        chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
        if (e.chk_data) chk("mem_data_out", mem_data_out, e.data);
      end
    end
  endtask

  // One clock: sample at negedge, then update the memory responder after the edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    dmem_bus.dmem_rsp_valid = 1'b0;
    if (rsp_pending && !suppress_rsp) begin
      dmem_bus.dmem_rsp_valid = 1'b1;
      dmem_bus.dmem_rdata     = rsp_data;
      rsp_pending             = 1'b0;
    end
    if (dmem_bus.dmem_req && ready_wait == 0) begin
      dmem_bus.dmem_ready = 1'b1;
    end else begin
      dmem_bus.dmem_ready = 1'b0;
      if (dmem_bus.dmem_req) ready_wait--;
    end
  endtask

  task automatic clear_counts();
    stall_cnt = 0; hs_cnt = 0; req_cnt = 0;
  endtask

  task automatic set_op(input logic [31:0] pc, addr, sdata, input logic [4:0] rd,
                        input logic regw, input logic [1:0] wbsel,
                        input logic memr, memw, input logic [2:0] f3);
    pc_in = pc; alu_result_in = addr; store_data_in = sdata; rd_in = rd;
    regW_in = regw; WBSel_in = wbsel; memR_in = memr; memW_in = memw; funct3_in = f3;
  endtask

  task automatic issue(input logic [31:0] pc, addr, sdata, input logic [4:0] rd,
                       input logic regw, input logic [1:0] wbsel,
                       input logic memr, memw, input logic [2:0] f3);
    set_op(pc, addr, sdata, rd, regw, wbsel, memr, memw, f3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    memR_in = 1'b0; memW_in = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic load_start(input logic [31:0] pc, addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] rdata, expd, input logic [3:0] be);
    exp_t e;
    clear_counts();
    rsp_data = rdata; exp_addr = {addr[31:2], 2'b00}; exp_be = be; exp_we = 1'b0;
    e = '{pc: pc, alu: addr, data: expd, rd: rd, regw: 1'b1, wbsel: 2'b01, mis: 1'b0, chk_data: 1'b1};
    sb.push_back(e);
    issue(pc, addr, 32'h0, rd, 1'b1, 2'b01, 1'b1, 1'b0, f3);
  endtask

  task automatic load(input logic [31:0] pc, addr, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] rdata, expd, input logic [3:0] be);
    load_start(pc, addr, f3, rd, rdata, expd, be);
    wait_done();
  endtask

  task automatic store(input logic [31:0] pc, addr, sdata, input logic [2:0] f3,
                       input logic [3:0] be, input logic [31:0] wdata);
    exp_t e;
    clear_counts();
    exp_addr = {addr[31:2], 2'b00}; exp_be = be; exp_we = 1'b1; exp_wdata = wdata;
    e = '{pc: pc, alu: addr, data: 32'h0, rd: 5'd0, regw: 1'b0, wbsel: 2'b00, mis: 1'b0, chk_data: 1'b0};
    sb.push_back(e);
    issue(pc, addr, sdata, 5'd0, 1'b1, 2'b00, 1'b0, 1'b1, f3);
    wait_done();
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
    set_op(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rsp_valid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    ready_wait = 0; rsp_pending = 1'b0; suppress_rsp = 1'b0; rsp_data = 32'h0;
    exp_addr = 32'h0; exp_be = 4'h0; exp_we = 1'b0; exp_wdata = 32'h0;
    clear_counts();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dmem_req", {31'h0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_stall_req", {31'h0, stall_req}, 32'd0);
    chk("rst_misalign", {31'h0, misalign}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Non-memory op passes straight through
    clear_counts();
    e = '{pc: 32'h40, alu: 32'h1234, data: 32'h0, rd: 5'd3, regw: 1'b1, wbsel: 2'b00, mis: 1'b0, chk_data: 1'b0};
    sb.push_back(e);
    issue(32'h40, 32'h1234, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, F3_W);
    chk("alu_drained", sb.size(), 32'd0);
    chk("alu_stall_cycles", stall_cnt, 32'd0);

    // LW and sub-word loads
    load(32'h50, 32'h100, F3_W, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
    chk("lw_stall_cycles", stall_cnt, 32'd2);
    chk("lw_handshakes", hs_cnt, 32'd1);
    load(32'h54, 32'h103, F3_B, 5'd6, 32'h80FFFFFF, 32'hFFFFFF80, 4'b1000);
    load(32'h58, 32'h103, F3_BU, 5'd7, 32'h80FFFFFF, 32'h00000080, 4'b1000);
    load(32'h5C, 32'h102, F3_HU, 5'd8, 32'hBEEF1234, 32'h0000BEEF, 4'b1100);
    load(32'h60, 32'h102, F3_H, 5'd9, 32'h80010000, 32'hFFFF8001, 4'b1100);

    // Stores, including a slow memory
    store(32'h64, 32'h101, 32'h000000AB, F3_B, 4'b0010, 32'hABABABAB);
    chk("sb_stall_cycles", stall_cnt, 32'd1);
    ready_wait = 3;
    store(32'h68, 32'h102, 32'h12345678, F3_H, 4'b1100, 32'h56785678);
    chk("slow_stall_cycles", stall_cnt, 32'd4);
    chk("slow_req_cycles", req_cnt, 32'd4);
    chk("slow_handshakes", hs_cnt, 32'd1);

    // Flush kills a load in IDLE
    clear_counts();
    flush = 1'b1;
    issue(32'h6C, 32'h100, 32'h0, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0, F3_W);
    flush = 1'b0;
    chk("flush_out_valid", {31'h0, last_ov}, 32'd0);
    chk("flush_regW", {31'h0, last_regw}, 32'd0);
    repeat (3) tick();
    chk("flush_no_req", req_cnt, 32'd0);

    // Flush after acceptance is ignored
    load_start(32'h70, 32'h200, F3_W, 5'd10, 32'h11223344, 32'h11223344, 4'b1111);
    flush = 1'b1;
    wait_done();
    flush = 1'b0;
    chk("flush_rsp_handshakes", hs_cnt, 32'd1);

    // stall_in blocks acceptance, then freezes HOLD
    clear_counts();
    rsp_data = 32'hCAFEF00D; exp_addr = 32'h104; exp_be = 4'b1111; exp_we = 1'b0;
    e = '{pc: 32'h74, alu: 32'h104, data: 32'hCAFEF00D, rd: 5'd11, regw: 1'b1, wbsel: 2'b01, mis: 1'b0, chk_data: 1'b1};
    sb.push_back(e);
    set_op(32'h74, 32'h104, 32'h0, 5'd11, 1'b1, 2'b01, 1'b1, 1'b0, F3_W);
    in_valid = 1'b1; stall_in = 1'b1;
    repeat (2) tick();
    chk("stall_blocks_accept", req_cnt, 32'd0);
    stall_in = 1'b0;
    tick();
    in_valid = 1'b0; memR_in = 1'b0; stall_in = 1'b1;
    repeat (6) tick();
    chk("hold_out_valid", {31'h0, last_ov}, 32'd1);
    chk("hold_stall_req", {31'h0, last_sr}, 32'd1);
    chk("hold_data", last_data, 32'hCAFEF00D);
    chk("hold_not_taken", sb.size(), 32'd1);
    stall_in = 1'b0;
    wait_done();

    // Low address bits of a word access
`ifdef MISALIGN_TRAP_EN
    clear_counts();
    e = '{pc: 32'h78, alu: 32'h102, data: 32'h0, rd: 5'd12, regw: 1'b0, wbsel: 2'b01, mis: 1'b1, chk_data: 1'b0};
    sb.push_back(e);
    issue(32'h78, 32'h102, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 1'b0, F3_W);
    wait_done();
    chk("misalign_no_req", req_cnt, 32'd0);
`else
    load(32'h78, 32'h102, F3_W, 5'd12, 32'h55AA1234, 32'h55AA1234, 4'b1111);
`endif

    // Reset while waiting for the response; late response ignored
    clear_counts();
    suppress_rsp = 1'b1; exp_addr = 32'h300; exp_be = 4'b1111; exp_we = 1'b0;
    issue(32'h7C, 32'h300, 32'h0, 5'd13, 1'b1, 2'b01, 1'b1, 1'b0, F3_W);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrsp_dmem_req", {31'h0, dmem_bus.dmem_req}, 32'd0);
    chk("rstrsp_stall_req", {31'h0, stall_req}, 32'd0);
    chk("rstrsp_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rstrsp_misalign", {31'h0, misalign}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; suppress_rsp = 1'b0; rsp_pending = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b1; dmem_bus.dmem_rdata = 32'h99999999;
    clear_counts();
    repeat (3) tick();
    chk("late_rsp_out_valid", {31'h0, last_ov}, 32'd0);
    chk("late_rsp_stall", stall_cnt, 32'd0);
    chk("late_rsp_no_req", req_cnt, 32'd0);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
